if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the five-stage pipeline. It sits between `instr_mem` and `cpu` decode. It owns the program counter and drives `instr_addr` to the instruction memory. It captures the returned word into the IF/ID pipeline register and honours stall, flush and branch-redirect requests coming back from later stages.

## Interface
Parameters:
- `XLEN`, 32, address and instruction width.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `NOP_INSTR`, 32'h0000_0013, bubble word (`addi x0,x0,0`).

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr_addr` out XLEN: fetch address to `instr_mem`; equals the PC register.
- `instr` in XLEN: `instr_mem` read data, combinational from `instr_addr`.
- `stall` in 1: hold the PC and IF/ID contents.
- `flush` in 1: squash the IF/ID contents.
- `redirect_valid` in 1: load a new PC (taken branch or jump).
- `redirect_pc` in XLEN: redirect target.
- `IF_ID_instr` out XLEN: latched instruction.
- `IF_ID_pc` out XLEN: PC of the latched instruction.
- `IF_ID_valid` out 1: the IF/ID slot holds a real instruction.
- `misalign_err` out 1: misaligned redirect trap active.

## Operation
FSM states: `BOOT`, `RUN`, `TRAP`.

- **Reset (async):**
  - PC = `RESET_PC`, state = `BOOT`.
  - `IF_ID_instr` = `NOP_INSTR`, `IF_ID_pc` = 0, `IF_ID_valid` = 0.
  - `misalign_err` = 0.
- **`BOOT`:**
  - Lasts one cycle; no capture, IF/ID stays a bubble.
  - PC is held; next state is `RUN`.
  - All inputs are ignored.
- **`RUN`:** per-edge priority, highest first.
  1. **`redirect_valid`:**
     - PC ← `redirect_pc`.
     - IF/ID ← bubble (`NOP_INSTR`, valid 0).
     - Wins over `stall` and `flush`.
  2. **`flush`:**
     - IF/ID ← bubble.
     - PC ← PC+4, unless `stall` is also high, in which case PC holds.
  3. **`stall`:** PC and IF/ID hold.
  4. **Otherwise:**
     - IF/ID ← {`instr`, PC, valid 1}.
     - PC ← PC+4.
- **`TRAP`:** described under Configuration.

Arithmetic:
- PC+4 is modulo 2^XLEN; from 32'hFFFF_FFFC it wraps to 0 with no flag.
- Without the configuration macro, `redirect_pc[1:0]` is forced to 0 on load.

## Timing
- Fetch-to-IF/ID latency is 1 cycle: the word at PC p appears on `IF_ID_instr` the edge after `instr_addr` = p, provided that edge is not stalled.
- First valid instruction appears 2 edges after `rst_n` rises: the BOOT edge, then the capture edge. That instruction is at `RESET_PC`.
- Redirect penalty is 1 bubble:
  - The edge sampling `redirect_valid` drives `instr_addr` = target.
  - The next unstalled edge presents the target instruction as valid.
- A stall held for N cycles freezes all outputs for N edges; the sequence then resumes with no loss or duplication.
- Reset asserted mid-operation clears all state immediately, without waiting for an edge; no partial update survives.

## Configuration
- `IF_MISALIGN_TRAP_EN` defined:
  - A redirect with `redirect_pc[1:0]` ≠ 0 does not load the PC; PC holds its old value.
  - IF/ID ← bubble, and state moves to `TRAP`.
  - In `TRAP`:
    - `misalign_err` = 1 and `IF_ID_valid` = 0 every cycle.
    - `stall` and `flush` are ignored.
  - An aligned `redirect_valid` loads the PC, clears `misalign_err` and returns to `RUN`.
  - A misaligned redirect seen while in `TRAP` keeps the block in `TRAP`.
- `IF_MISALIGN_TRAP_EN` undefined:
  - Low bits of the target are silently masked.
  - `TRAP` is unreachable and `misalign_err` is tied to 0.

## Structure
- Shared package `cpu_pkg`:
  - `XLEN`.
  - `NOP_INSTR`.
  - `if_state_t` enum (`BOOT`, `RUN`, `TRAP`).
  - The `if_id_t` struct {instr, pc, valid}, which the `cpu` decode stage also uses.
- One sub-module, `pc_reg`: holds the PC register, next-PC mux and +4 adder.
- The FSM and the IF/ID register stay in `if_stage`.

## Test plan
- **Reset release:** `RESET_PC`=0, memory word0=0x00500093 → `IF_ID_valid` first 1 on the 2nd edge after `rst_n` rises, with `IF_ID_instr`=0x00500093 and `IF_ID_pc`=0.
- **Sequential fetch:** 4 unstalled edges → `IF_ID_pc` steps 0, 4, 8, 0xC, each with its matching memory word.
- **Stall then flush:**
  - `stall` high for 3 cycles at PC=8 → `instr_addr` stays 8 and IF/ID holds.
  - `stall`+`flush` on the same edge → IF/ID becomes the bubble, PC stays 8.
- **Redirect priority:** `redirect_valid`=1 to 0x40 together with `stall`=1 → `instr_addr`=0x40 after the edge, one bubble, then `IF_ID_pc`=0x40 valid.
- **Wrap:** PC=0xFFFF_FFFC, unstalled edge → `instr_addr`=0.
- **Misaligned redirect:** `redirect_pc`=0x42.
  - With `IF_MISALIGN_TRAP_EN`: `misalign_err`=1 and `instr_addr` unchanged; a later redirect to 0x80 clears the error and valid fetch resumes at 0x80.
  - Without the macro: `instr_addr`=0x40.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants: machine width, bubble word, fetch FSM states
// and the IF/ID payload also consumed by the decode stage.
package cpu_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } if_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: instruction memory port, pipeline control and IF/ID outputs.
interface if_stage_if #(
  parameter int unsigned XLEN = cpu_pkg::XLEN
);

  logic [XLEN-1:0] instr_addr;
  logic [XLEN-1:0] instr;
  logic            stall;
  logic            flush;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] IF_ID_instr;
  logic [XLEN-1:0] IF_ID_pc;
  logic            IF_ID_valid;
  logic            misalign_err;

  modport master (
    output instr_addr, IF_ID_instr, IF_ID_pc, IF_ID_valid, misalign_err,
    input  instr, stall, flush, redirect_valid, redirect_pc
  );

  modport slave (
    input  instr_addr, IF_ID_instr, IF_ID_pc, IF_ID_valid, misalign_err,
    output instr, stall, flush, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/pc_reg.sv
// Program counter: register, load/increment mux and modulo-2^XLEN +4 adder.
module pc_reg #(
  parameter int unsigned     XLEN     = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_en,
  input  logic [XLEN-1:0] load_pc,
  input  logic            inc_en,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_next;

  // Load wins over increment; the adder wraps silently.
  always_comb begin
    pc_next = pc;
    if (load_en) begin
      pc_next = load_pc;
    end else if (inc_en) begin
      pc_next = pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: BOOT/RUN/TRAP control, PC sequencing and IF/ID register.
// Optional misaligned-redirect trap enabled by defining IF_MISALIGN_TRAP_EN.
module if_stage #(
  parameter int unsigned     XLEN      = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(cpu_pkg::NOP_INSTR)
) (
  input  logic       clk,
  input  logic       rst_n,
  if_stage_if.master bus
);

  import cpu_pkg::*;

  if_state_t       state_q, state_d;
  if_id_t          ifid_q, ifid_d;
  logic            err_q, err_d;
  logic            pc_load, pc_inc;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] load_pc;
  if_id_t          bubble;

`ifdef IF_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = |bus.redirect_pc[1:0];
  assign load_pc    = bus.redirect_pc;
`else
  assign load_pc    = bus.redirect_pc & ~XLEN'(3);
`endif

  assign bubble = '{instr: NOP_INSTR, pc: ifid_q.pc, valid: 1'b0};

  pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_en (pc_load),
    .load_pc (load_pc),
    .inc_en  (pc_inc),
    .pc      (pc)
  );

  // Next-state, IF/ID and PC control; redirect > flush > stall > capture.
  always_comb begin
    state_d = state_q;
    ifid_d  = ifid_q;
    err_d   = err_q;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (bus.redirect_valid) begin
          ifid_d = bubble;
`ifdef IF_MISALIGN_TRAP_EN
          if (misaligned) begin
            state_d = TRAP;
            err_d   = 1'b1;
          end else begin
            pc_load = 1'b1;
          end
`else
          pc_load = 1'b1;
`endif
        end else if (bus.flush) begin
          ifid_d = bubble;
          pc_inc = !bus.stall;
        end else if (!bus.stall) begin
          ifid_d = '{instr: bus.instr, pc: pc, valid: 1'b1};
          pc_inc = 1'b1;
        end
      end
      TRAP: begin
        ifid_d = bubble;
`ifdef IF_MISALIGN_TRAP_EN
        if (bus.redirect_valid && !misaligned) begin
          pc_load = 1'b1;
          err_d   = 1'b0;
          state_d = RUN;
        end
`else
        state_d = RUN;
`endif
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      ifid_q  <= '{instr: NOP_INSTR, pc: '0, valid: 1'b0};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ifid_q  <= ifid_d;
      err_q   <= err_d;
    end
  end

  assign bus.instr_addr   = pc;
  assign bus.IF_ID_instr  = ifid_q.instr;
  assign bus.IF_ID_pc     = ifid_q.pc;
  assign bus.IF_ID_valid  = ifid_q.valid;
  assign bus.misalign_err = err_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vector table, corner sequences and
// randomized traffic against a behavioural fetch model.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_stage_if bus ();

  if_stage #(.RESET_PC(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  always_comb bus.instr = mem_word(bus.instr_addr);

  int checks = 0;
  int errors = 0;

  // Behavioural model of the fetch stage as seen from outside.
  bit          m_booting, m_trapped, m_iv, m_err;
  logic [31:0] m_pc, m_ii, m_ip;

  task automatic model_reset();
    m_booting = 1'b1; m_trapped = 1'b0;
    m_pc = 32'h0; m_ii = NOP; m_ip = 32'h0; m_iv = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step(input bit rv, input logic [31:0] rp, input bit st, input bit fl);
    if (m_booting) begin
      m_booting = 1'b0;
    end else if (m_trapped) begin
      m_ii = NOP; m_iv = 1'b0;
      if (rv && rp[1:0] == 2'b00) begin
        m_pc = rp; m_trapped = 1'b0; m_err = 1'b0;
      end
    end else if (rv) begin
      m_ii = NOP; m_iv = 1'b0;
      if (TRAP_EN && rp[1:0] != 2'b00) begin
        m_trapped = 1'b1; m_err = 1'b1;
      end else begin
        m_pc = {rp[31:2], 2'b00};
      end
    end else if (fl) begin
      m_ii = NOP; m_iv = 1'b0;
      if (!st) m_pc = m_pc + 32'd4;
    end else if (!st) begin
      m_ii = mem_word(m_pc); m_ip = m_pc; m_iv = 1'b1;
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "/instr_addr"}, bus.instr_addr, m_pc);
    chk({tag, "/valid"}, 32'(bus.IF_ID_valid), 32'(m_iv));
    chk({tag, "/instr"}, bus.IF_ID_instr, m_ii);
    chk({tag, "/misalign_err"}, 32'(bus.misalign_err), 32'(m_err));
    if (m_iv) chk({tag, "/pc"}, bus.IF_ID_pc, m_ip);
  endtask

  // Drive inputs, take one edge, advance the model and compare shortly after.
  task automatic step(input bit rv, input logic [31:0] rp, input bit st, input bit fl);
    bus.redirect_valid = rv; bus.redirect_pc = rp; bus.stall = st; bus.flush = fl;
    @(posedge clk);
    model_step(rv, rp, st, fl);
    #1;
    check_model("model");
  endtask

  typedef struct {
    bit          rv;
    logic [31:0] rp;
    bit          st;
    bit          fl;
    logic [31:0] addr;
    bit          v;
    logic [31:0] pc;
    logic [31:0] ins;
    bit          err;
  } vec_t;

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h00, 1'b0, 32'h00, NOP,                 1'b0};
    tbl[1]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h04, 1'b1, 32'h00, 32'h0050_0093,       1'b0};
    tbl[2]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h08, 1'b1, 32'h04, mem_word(32'h04),    1'b0};
    tbl[3]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h08, 1'b1, 32'h04, mem_word(32'h04),    1'b0};
    tbl[4]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h08, 1'b1, 32'h04, mem_word(32'h04),    1'b0};
    tbl[5]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h08, 1'b1, 32'h04, mem_word(32'h04),    1'b0};
    tbl[6]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h08, 1'b0, 32'h00, NOP,                 1'b0};
    tbl[7]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0C, 1'b1, 32'h08, mem_word(32'h08),    1'b0};
    tbl[8]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h10, 1'b1, 32'h0C, mem_word(32'h0C),    1'b0};
    tbl[9]  = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h40, 1'b0, 32'h00, NOP,                 1'b0};
    tbl[10] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h44, 1'b1, 32'h40, mem_word(32'h40),    1'b0};
    tbl[11] = '{1'b1, 32'h42, 1'b0, 1'b0, TRAP_EN ? 32'h44 : 32'h40, 1'b0, 32'h00, NOP, TRAP_EN};
    tbl[12] = '{1'b0, 32'h0,  1'b1, 1'b1, TRAP_EN ? 32'h44 : 32'h40, 1'b0, 32'h00, NOP, TRAP_EN};
    tbl[13] = '{1'b1, 32'h80, 1'b0, 1'b0, 32'h80, 1'b0, 32'h00, NOP,                 1'b0};
    tbl[14] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h84, 1'b1, 32'h80, mem_word(32'h80),    1'b0};

    bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0; bus.stall = 1'b0; bus.flush = 1'b0;
    model_reset();
    #12;
    chk("reset/instr_addr", bus.instr_addr, 32'h0);
    chk("reset/valid", 32'(bus.IF_ID_valid), 32'h0);
    chk("reset/instr", bus.IF_ID_instr, NOP);
    chk("reset/pc", bus.IF_ID_pc, 32'h0);
    chk("reset/misalign_err", 32'(bus.misalign_err), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rv, tbl[i].rp, tbl[i].st, tbl[i].fl);
      chk($sformatf("vec%0d/instr_addr", i), bus.instr_addr, tbl[i].addr);
      chk($sformatf("vec%0d/valid", i), 32'(bus.IF_ID_valid), 32'(tbl[i].v));
      chk($sformatf("vec%0d/instr", i), bus.IF_ID_instr, tbl[i].ins);
      chk($sformatf("vec%0d/misalign_err", i), 32'(bus.misalign_err), 32'(tbl[i].err));
      if (tbl[i].v) chk($sformatf("vec%0d/pc", i), bus.IF_ID_pc, tbl[i].pc);
    end

    // PC wraps from the top of the address space to zero.
    step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("wrap/instr_addr", bus.instr_addr, 32'h0);
    chk("wrap/pc", bus.IF_ID_pc, 32'hFFFF_FFFC);
    chk("wrap/valid", 32'(bus.IF_ID_valid), 32'h1);

    // Asynchronous reset mid-stream clears everything before any edge.
    step(1'b0, 32'h0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst/instr_addr", bus.instr_addr, 32'h0);
    chk("async_rst/valid", 32'(bus.IF_ID_valid), 32'h0);
    chk("async_rst/instr", bus.IF_ID_instr, NOP);
    chk("async_rst/pc", bus.IF_ID_pc, 32'h0);
    #3 rst_n = 1'b1;
    step(1'b1, 32'h100, 1'b0, 1'b1);
    chk("boot_ignores/instr_addr", bus.instr_addr, 32'h0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("after_boot/instr", bus.IF_ID_instr, 32'h0050_0093);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] rp;
      bit rv, st, fl;
      rv = ($urandom_range(0, 7) == 0);
      rp = $urandom;
      if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 5) == 0);
      step(rv, rp, st, fl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
